// File: rtl/mac_window_feeder.sv
// mac_window_feeder
// Driver side of the smoother's MAC interface. It buffers two raster lines
// and forms 3x3 windows. Each window goes to the MAC as three packed rows on
// the MAC's 4-phase cadence: rows in phases 0-2, accumulator clear in phase 3.
// The MAC sum is captured in phase 3, normalised to an 8-bit pixel and queued
// on a valid/ready output.
// Build option: define MAC_FEED_ROUND_EN to add round-half-up before the
// normalising shift. When it is undefined the shift truncates.

// Watches the output queue: a result must never be pushed while it is full.
module mac_window_feeder_chk (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

module mac_window_feeder #(
    parameter int IMG_WIDTH  = 64,
    parameter int NORM_SHIFT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [7:0]  pix_data,
    input  logic [71:0] kernel,
    output logic [23:0] mac_data,
    output logic [23:0] mac_weight,
    input  logic [19:0] mac_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
`ifdef MAC_FEED_ROUND_EN
    // Half of one output LSB, or zero when there is no shift.
    localparam logic signed [20:0] ROUND_C = (21'sd1 <<< NORM_SHIFT) >>> 1;
`endif

    // Arithmetic shift by NORM_SHIFT, then saturation into the 0..255 pixel range.
    function automatic logic [7:0] norm_clamp(input logic signed [20:0] s);
        logic signed [20:0] v;
        v = s >>> NORM_SHIFT;
        if (v < 21'sd0) begin
            norm_clamp = 8'd0;
        end else if (v > 21'sd255) begin
            norm_clamp = 8'd255;
        end else begin
            norm_clamp = v[7:0];
        end
    endfunction

    // Registered state
    logic [1:0]    phase_r;
    logic [1:0]    row_r;          // saturates at 2: only "row >= 2" matters
    logic [CW-1:0] col_r;
    logic [7:0]    lb_near_r [IMG_WIDTH];   // line row-1
    logic [7:0]    lb_far_r  [IMG_WIDTH];   // line row-2
    logic [7:0]    win_top_r [3];           // index 0 = left column
    logic [7:0]    win_mid_r [3];
    logic [7:0]    win_bot_r [3];
    logic          busy_r;
    logic [23:0]   mac_data_r;
    logic [23:0]   mac_weight_r;
    logic          out_valid_r;
    logic [7:0]    out_data_r;
    logic          q1_valid_r;
    logic [7:0]    q1_data_r;

    // Combinational helpers
    logic          pop_s;
    logic          capture_s;
    logic [2:0]    credit_s;
    logic          pix_ready_s;
    logic          accept_s;
    logic [1:0]    cur_row_s;
    logic [CW-1:0] cur_col_s;
    logic [1:0]    nxt_row_s;
    logic [CW-1:0] nxt_col_s;
    logic          launch_s;
    logic [7:0]    far_px_s;
    logic [7:0]    near_px_s;
    logic signed [20:0] sum_s;
    logic [7:0]    result_s;
    logic [23:0]   mac_data_nxt_s;
    logic [23:0]   mac_weight_nxt_s;
    logic          hd_valid_s;
    logic [7:0]    hd_data_s;
    logic          tl_valid_s;
    logic [7:0]    tl_data_s;
    logic          full_s;

    // Free-running phase. It leaves reset on the same edge as the MAC's counter, so the two stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= 2'd0;
        end else begin
            phase_r <= phase_r + 2'd1;
        end
    end

    // Handshakes and the credit rule: accept only in phase 3 when results in flight stay below two.
    always_comb begin
        pop_s       = out_valid_r && out_ready;
        capture_s   = busy_r && (phase_r == 2'd3);
        credit_s    = {2'b00, out_valid_r} + {2'b00, q1_valid_r} + {2'b00, busy_r} - {2'b00, pop_s};
        pix_ready_s = (phase_r == 2'd3) && (credit_s < 3'd2);
        accept_s    = pix_valid && pix_ready_s;
    end

    // Position of the incoming pixel. sof restarts the frame at row 0, column 0.
    always_comb begin
        if (pix_sof) begin
            cur_row_s = 2'd0;
            cur_col_s = {CW{1'b0}};
        end else begin
            cur_row_s = row_r;
            cur_col_s = col_r;
        end
        if (cur_col_s == COL_LAST) begin
            nxt_col_s = {CW{1'b0}};
            nxt_row_s = (cur_row_s == 2'd2) ? 2'd2 : (cur_row_s + 2'd1);
        end else begin
            nxt_col_s = cur_col_s + CW'(1);
            nxt_row_s = cur_row_s;
        end
        launch_s  = accept_s && (cur_row_s == 2'd2) && (cur_col_s >= COL_TWO);
        far_px_s  = lb_far_r[cur_col_s];
        near_px_s = lb_near_r[cur_col_s];
    end

    // Raster counters, and a left shift of the 3x3 column window on every accepted pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_r <= 2'd0;
            col_r <= {CW{1'b0}};
            for (int i = 0; i < 3; i++) begin
                win_top_r[i] <= 8'd0;
                win_mid_r[i] <= 8'd0;
                win_bot_r[i] <= 8'd0;
            end
        end else if (accept_s) begin
            row_r <= nxt_row_s;
            col_r <= nxt_col_s;
            win_top_r[0] <= win_top_r[1];
            win_top_r[1] <= win_top_r[2];
            win_top_r[2] <= far_px_s;
            win_mid_r[0] <= win_mid_r[1];
            win_mid_r[1] <= win_mid_r[2];
            win_mid_r[2] <= near_px_s;
            win_bot_r[0] <= win_bot_r[1];
            win_bot_r[1] <= win_bot_r[2];
            win_bot_r[2] <= pix_data;
        end
    end

    // Two line memories. They are not reset: rows 0 and 1 of every frame overwrite them before any window uses them.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_far_r[cur_col_s]  <= near_px_s;
            lb_near_r[cur_col_s] <= pix_data;
        end
    end

    // Row selection for the MAC. The top row is taken at launch from the window being shifted in.
    always_comb begin
        mac_data_nxt_s   = 24'd0;
        mac_weight_nxt_s = 24'd0;
        if (launch_s) begin
            mac_data_nxt_s   = {far_px_s, win_top_r[2], win_top_r[1]};
            mac_weight_nxt_s = kernel[23:0];
        end else if (busy_r && (phase_r == 2'd0)) begin
            mac_data_nxt_s   = {win_mid_r[2], win_mid_r[1], win_mid_r[0]};
            mac_weight_nxt_s = kernel[47:24];
        end else if (busy_r && (phase_r == 2'd1)) begin
            mac_data_nxt_s   = {win_bot_r[2], win_bot_r[1], win_bot_r[0]};
            mac_weight_nxt_s = kernel[71:48];
        end else begin
            mac_data_nxt_s   = 24'd0;
            mac_weight_nxt_s = 24'd0;
        end
    end

    // Job flag and the registered MAC operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            mac_data_r   <= 24'd0;
            mac_weight_r <= 24'd0;
        end else begin
            if (launch_s) begin
                busy_r <= 1'b1;
            end else if (capture_s) begin
                busy_r <= 1'b0;
            end
            mac_data_r   <= mac_data_nxt_s;
            mac_weight_r <= mac_weight_nxt_s;
        end
    end

    // Sign-extend the accumulator, optionally add the rounding bias, then normalise.
    always_comb begin
`ifdef MAC_FEED_ROUND_EN
        sum_s = $signed({mac_result[19], mac_result}) + ROUND_C;
`else
        sum_s = $signed({mac_result[19], mac_result});
`endif
        result_s = norm_clamp(sum_s);
    end

    // Next state of the 2-entry output queue: pop first, then push into the first free slot.
    always_comb begin
        if (pop_s) begin
            hd_valid_s = q1_valid_r;
            hd_data_s  = q1_valid_r ? q1_data_r : out_data_r;
            tl_valid_s = 1'b0;
            tl_data_s  = q1_data_r;
        end else begin
            hd_valid_s = out_valid_r;
            hd_data_s  = out_data_r;
            tl_valid_s = q1_valid_r;
            tl_data_s  = q1_data_r;
        end
        full_s = hd_valid_s && tl_valid_s;
        if (capture_s && !hd_valid_s) begin
            hd_valid_s = 1'b1;
            hd_data_s  = result_s;
        end else if (capture_s && !tl_valid_s) begin
            tl_valid_s = 1'b1;
            tl_data_s  = result_s;
        end else begin
            hd_valid_s = hd_valid_s;
            tl_valid_s = tl_valid_s;
        end
    end

    // Output queue registers. The head drives out_valid and out_data directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            q1_valid_r  <= 1'b0;
            q1_data_r   <= 8'd0;
        end else begin
            out_valid_r <= hd_valid_s;
            out_data_r  <= hd_data_s;
            q1_valid_r  <= tl_valid_s;
            q1_data_r   <= tl_data_s;
        end
    end

    mac_window_feeder_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (capture_s),
        .full    (full_s)
    );

    assign pix_ready  = pix_ready_s;
    assign mac_data   = mac_data_r;
    assign mac_weight = mac_weight_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;

endmodule

// File: tb/tb_mac_window_feeder.sv
// Bench for mac_window_feeder. A behavioural MAC stands in for the real one.
// A frame-level reference (pixel image + window sums) predicts every output
// value, the cycle it appears, and the pix_ready credit rule.
module tb_mac_window_feeder;

    localparam int W = 4;
    localparam int S = 3;
`ifdef MAC_FEED_ROUND_EN
    localparam int R76 = 10;
`else
    localparam int R76 = 9;
`endif

    logic        clk;
    logic        reset_n;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic [7:0]  pix_data;
    logic [71:0] kernel;
    logic [23:0] mac_data;
    logic [23:0] mac_weight;
    logic [19:0] mac_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    typedef struct { int val; int due; } exp_t;
    exp_t        exp_q[$];
    int          got_q[$];
    logic [7:0]  img [0:255][0:W-1];
    int          mr, mc, cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode;     // 0 hold low, 1 hold high, 2 random
    logic [1:0]  mph;
    int          macc;

    mac_window_feeder #(.IMG_WIDTH(W), .NORM_SHIFT(S)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .kernel     (kernel),
        .mac_data   (mac_data),
        .mac_weight (mac_weight),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Unsigned pixels times signed weights, three lanes.
    function automatic int dot3(input logic [23:0] d, input logic [23:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(d[8*k +: 8]) * int'($signed(w[8*k +: 8]));
        return s;
    endfunction

    // Behavioural MAC: accumulates in phases 0-2 and clears in phase 3.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mph  <= 2'd0;
            macc <= 0;
        end else begin
            mph  <= mph + 2'd1;
            macc <= (mph == 2'd3) ? 0 : macc + dot3(mac_data, mac_weight);
        end
    end
    assign mac_result = macc[19:0];

    // Expected smoothed pixel for a window centred on (r-1, c-1).
    function automatic int calc(input int r, input int c);
        int sum, v;
        sum = 0;
        for (int k = 0; k < 9; k++)
            sum += int'($signed(kernel[8*k +: 8])) * int'(img[r-2+k/3][c-2+k%3]);
`ifdef MAC_FEED_ROUND_EN
        if (S > 0) sum += (1 << S) / 2;
`endif
        v = sum >>> S;
        if (v < 0) v = 0;
        else if (v > 255) v = 255;
        return v;
    endfunction

    // Reference model and scoreboard. It samples at the falling edge what the next rising edge will do.
    initial begin
        logic pop;
        int   exp_rdy, exp_ov;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                mr = 0; mc = 0; cyc = 0;
            end else begin
                pop = out_valid && out_ready;
                exp_rdy = ((cyc % 4) == 3 && (exp_q.size() - (pop ? 1 : 0)) < 2) ? 1 : 0;
                check_eq("pix_ready", int'(pix_ready), exp_rdy);
                exp_ov = (exp_q.size() > 0 && exp_q[0].due <= cyc) ? 1 : 0;
                check_eq("out_valid", int'(out_valid), exp_ov);
                if (pop && exp_q.size() > 0) begin
                    check_eq("out_data", int'(out_data), exp_q[0].val);
                    got_q.push_back(int'(out_data));
                    void'(exp_q.pop_front());
                end
                if (pix_valid && pix_ready) begin
                    if (pix_sof) begin mr = 0; mc = 0; end
                    img[mr][mc] = pix_data;
                    if (mr >= 2 && mc >= 2) exp_q.push_back('{calc(mr, mc), cyc + 5});
                    if (mc == W - 1) begin
                        mc = 0;
                        if (mr < 255) mr++;
                    end else begin
                        mc++;
                    end
                end
                cyc++;
            end
        end
    end

    // Drives out_ready according to the current mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom % 2);
            endcase
        end
    end

    task automatic send_pix(input logic [7:0] d, input logic sof);
        logic got;
        got = 1'b0;
        pix_data = d; pix_sof = sof; pix_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pix_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        check_eq("accept", int'(got), 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_pix(d, (i == 0) ? 1'b1 : 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check_eq("idle", exp_q.size(), 0);
    endtask

    // One 12-pixel frame of constant value: two windows expected.
    task automatic run_dir(input string tag, input logic [7:0] d, input int e0, input int e1);
        got_q.delete();
        send_frame(d, 12);
        wait_idle();
        check_eq({tag, "_n"}, got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq({tag, "_v0"}, got_q[0], e0);
            check_eq({tag, "_v1"}, got_q[1], e1);
        end
    endtask

    initial begin
        int n_acc, n_ov, n;
        logic [95:0] rk;
        ready_mode = 1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'd0;
        kernel = {9{8'h01}};
        reset_n = 1'b0;

        // Reset state
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_rdy", int'(pix_ready), 0);
            check_eq("rst_ov", int'(out_valid), 0);
            check_eq("rst_od", int'(out_data), 0);
            check_eq("rst_md", int'(mac_data), 0);
            check_eq("rst_mw", int'(mac_weight), 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t1_first_rdy", int'(pix_ready), (i == 3) ? 1 : 0);
        end
        @(posedge clk); #1;

        // Basic smoothing: all-ones kernel, pixel 8 -> 72>>3 = 9
        run_dir("t2", 8'd8, 9, 9);

        // Back-pressure: two results held, input blocked, then drained in order
        ready_mode = 0;
        @(posedge clk); #1;
        got_q.delete();
        send_frame(8'd8, 12);
        pix_valid = 1'b1; pix_data = 8'd8;
        n_acc = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (pix_ready) n_acc++;
        end
        check_eq("t3_stall", n_acc, 0);
        check_eq("t3_held", int'(out_valid), 1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        ready_mode = 1;
        send_pix(8'd8, 1'b0);
        wait_idle();
        check_eq("t3_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq("t3_v0", got_q[0], 9);
            check_eq("t3_v1", got_q[1], 9);
        end

        // Clamping: 200*127>>3 saturates high; 200*(-1)>>3 saturates low
        kernel = 72'd0; kernel[39:32] = 8'h7F;
        run_dir("t4_hi", 8'd200, 255, 255);
        kernel[39:32] = 8'hFF;
        run_dir("t4_lo", 8'd200, 0, 0);

        // Rounding boundary: sums 75 and 76 with a shift of 3
        kernel[39:32] = 8'h01;
        run_dir("t5_75", 8'd75, 9, 9);
        run_dir("t5_76", 8'd76, R76, R76);

        // Reset during phase 1 of a job
        kernel = {9{8'h01}};
        send_frame(8'd8, 11);
        @(posedge clk); #1;
        reset_n = 1'b0;
        n_ov = 0;
        repeat (3) begin @(negedge clk); n_ov += int'(out_valid); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) begin @(negedge clk); n_ov += int'(out_valid); end
        check_eq("t6_no_out", n_ov, 0);
        @(posedge clk); #1;
        run_dir("t6_rerun", 8'd8, 9, 9);

        // Randomised frames, kernels, gaps, mid-frame sof and back-pressure
        ready_mode = 2;
        for (int f = 0; f < 8; f++) begin
            wait_idle();
            rk = {$urandom, $urandom, $urandom};
            kernel = rk[71:0];
            n = $urandom_range(12, 36);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_pix(8'($urandom), (i == 0 || ($urandom % 16) == 0) ? 1'b1 : 1'b0);
            end
        end
        ready_mode = 1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
